// File: rtl/sparc_ifu_swsched_pkg.sv
// Shared definitions for the IFU thread-switch scheduler.
// Contents:
//   thr_state_e  - 2-bit per-thread run state encoding
//   *_DEF        - default thread count, run quantum and quantum counter width
package sparc_ifu_swsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RDY  = 2'b01,
        ST_RUN  = 2'b10,
        ST_WAIT = 2'b11
    } thr_state_e;

    localparam int NTHR_DEF    = 4;
    localparam int QUANTUM_DEF = 16;
    localparam int QBITS_DEF   = 5;

endpackage

// File: rtl/sparc_ifu_swsched_rrarb.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per thread
//   ptr     - one-hot pointer to the last winner; search starts one above it
//   gnt     - one-hot grant (all-zero when no request)
//   any_gnt - at least one request granted
module sparc_ifu_swsched_rrarb #(
    parameter int NTHR = 4
) (
    input  logic [NTHR-1:0] req,
    input  logic [NTHR-1:0] ptr,
    output logic [NTHR-1:0] gnt,
    output logic            any_gnt
);

    int pidx;
    int idx;

    always_comb begin
        gnt     = '0;
        any_gnt = 1'b0;
        pidx    = 0;
        idx     = 0;
        for (int i = 0; i < NTHR; i++) begin
            if (ptr[i]) pidx = i;
        end
        // Walk ptr+1 .. ptr+NTHR so the previous winner has lowest priority.
        for (int k = 1; k <= NTHR; k++) begin
            idx = (pidx + k) % NTHR;
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparc_ifu_swsched.sv
// Per-core thread-switch scheduler: keeps per-thread run state and selects
// the one thread that fetches next, round-robin, with a forced fairness
// switch after a run quantum.
// Ports:
//   rclk, reset   - clock, asynchronous active-high reset
//   thr_en        - per-thread enable level
//   fdp_inst_vld  - valid S-stage instruction of the running thread
//   fdp_swc       - switch-condition decode, qualified by fdp_inst_vld
//   thr_done      - long-latency completion pulses
//   stall         - freezes run/pick decisions (disable still acts)
//   sel_thr       - registered one-hot of the RUN thread
//   sel_vld       - registered |sel_thr
//   thr_wait      - registered per-thread WAIT flags
//   switch_out    - registered pulse, a grant occurred
module sparc_ifu_swsched
    import sparc_ifu_swsched_pkg::*;
#(
    parameter int NTHR    = NTHR_DEF,
    parameter int QUANTUM = QUANTUM_DEF,
    parameter int QBITS   = QBITS_DEF
) (
    input  logic            rclk,
    input  logic            reset,
    input  logic [NTHR-1:0] thr_en,
    input  logic            fdp_inst_vld,
    input  logic            fdp_swc,
    input  logic [NTHR-1:0] thr_done,
    input  logic            stall,
    output logic [NTHR-1:0] sel_thr,
    output logic            sel_vld,
    output logic [NTHR-1:0] thr_wait,
    output logic            switch_out
);

    localparam logic [QBITS-1:0] QMAX = QBITS'(QUANTUM - 1);

    thr_state_e       st  [NTHR];
    thr_state_e       nxt [NTHR];
    logic [NTHR-1:0]  run_vec, rdy_vec, nxt_run, nxt_wait;
    logic [NTHR-1:0]  rr_ptr, gnt, req;
    logic [QBITS-1:0] cnt;
    logic             any_gnt, has_run, other_rdy;
    logic             do_swc, do_force, run_dis, departing, pick, grant;

    always_comb begin
        run_vec = '0;
        rdy_vec = '0;
        for (int i = 0; i < NTHR; i++) begin
            run_vec[i] = (st[i] == ST_RUN);
            rdy_vec[i] = (st[i] == ST_RDY);
        end
    end

    assign has_run   = |run_vec;
    // Only threads already RDY in the current state count; fresh RDYs wait a cycle.
    assign other_rdy = |(rdy_vec & thr_en);
    assign do_swc    = !stall && has_run && fdp_inst_vld && fdp_swc;
    assign do_force  = !stall && has_run && fdp_inst_vld && !fdp_swc &&
                       (cnt == QMAX) && other_rdy;
    assign run_dis   = |(run_vec & ~thr_en);
    assign departing = run_dis || do_swc || do_force;
    assign pick      = !stall && (departing || !has_run);
    assign req       = rdy_vec & thr_en & ~run_vec;
    assign grant     = pick && any_gnt;

    sparc_ifu_swsched_rrarb #(.NTHR(NTHR)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .any_gnt (any_gnt)
    );

    always_comb begin
        nxt_run  = '0;
        nxt_wait = '0;
        for (int i = 0; i < NTHR; i++) begin
            nxt[i] = st[i];
            if (!thr_en[i]) begin
                nxt[i] = ST_IDLE;
            end else begin
                unique case (st[i])
                    ST_IDLE: nxt[i] = ST_RDY;
                    ST_RDY:  if (grant && gnt[i]) nxt[i] = ST_RUN;
                    ST_WAIT: if (thr_done[i]) nxt[i] = ST_RDY;
                    ST_RUN: begin
                        // A completion racing the switch makes WAIT pointless.
                        if (do_swc)        nxt[i] = thr_done[i] ? ST_RDY : ST_WAIT;
                        else if (do_force) nxt[i] = ST_RDY;
                    end
                endcase
            end
            nxt_run[i]  = (nxt[i] == ST_RUN);
            nxt_wait[i] = (nxt[i] == ST_WAIT);
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTHR; i++) st[i] <= ST_IDLE;
            cnt        <= '0;
            rr_ptr     <= {1'b1, {(NTHR-1){1'b0}}};
            sel_thr    <= '0;
            sel_vld    <= 1'b0;
            thr_wait   <= '0;
            switch_out <= 1'b0;
        end else begin
            for (int i = 0; i < NTHR; i++) st[i] <= nxt[i];
            sel_thr    <= nxt_run;
            sel_vld    <= |nxt_run;
            thr_wait   <= nxt_wait;
            switch_out <= grant;
            if (grant) begin
                rr_ptr <= gnt;
                cnt    <= '0;
            end else if (!stall && has_run && fdp_inst_vld && (cnt != QMAX)) begin
                cnt <= cnt + QBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_sparc_ifu_swsched.sv
module tb_sparc_ifu_swsched;

  localparam int NT = 4;
  localparam int QUANTUM = 16;

  logic          rclk = 1'b0;
  logic          reset;
  logic [NT-1:0] thr_en;
  logic          fdp_inst_vld;
  logic          fdp_swc;
  logic [NT-1:0] thr_done;
  logic          stall;
  logic [NT-1:0] sel_thr;
  logic          sel_vld;
  logic [NT-1:0] thr_wait;
  logic          switch_out;

  int total = 0;
  int bad = 0;

  // expected {sel_thr, sel_vld, thr_wait, switch_out}
  logic [9:0] exp_q[$];

  // reference model: 0=IDLE 1=RDY 2=RUN 3=WAIT
  int m_st[NT];
  int m_cnt;
  int m_ptr;

  sparc_ifu_swsched #(.NTHR(NT), .QUANTUM(QUANTUM), .QBITS(5)) dut (
    .rclk         (rclk),
    .reset        (reset),
    .thr_en       (thr_en),
    .fdp_inst_vld (fdp_inst_vld),
    .fdp_swc      (fdp_swc),
    .thr_done     (thr_done),
    .stall        (stall),
    .sel_thr      (sel_thr),
    .sel_vld      (sel_vld),
    .thr_wait     (thr_wait),
    .switch_out   (switch_out)
  );

  // clock / reset
  always #5 rclk = ~rclk;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_st[i] = 0;
    m_cnt = 0;
    m_ptr = NT - 1;
    exp_q.delete();
  endtask

  function automatic int m_run();
    int r;
    r = -1;
    for (int i = 0; i < NT; i++) if (m_st[i] == 2) r = i;
    return r;
  endfunction

  // advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int run, win, other, j;
    bit dep, sw;
    int ns[NT];
    logic [NT-1:0] s, w;
    run = m_run(); dep = 0; sw = 0; other = 0; win = -1;
    for (int i = 0; i < NT; i++) begin
      ns[i] = m_st[i];
      if (m_st[i] == 1 && thr_en[i]) other++;
    end
    for (int i = 0; i < NT; i++) begin
      if (!thr_en[i]) ns[i] = 0;
      else if (m_st[i] == 0) ns[i] = 1;
      else if (m_st[i] == 3 && thr_done[i]) ns[i] = 1;
    end
    if (run >= 0) begin
      if (!thr_en[run]) dep = 1;
      else if (!stall && fdp_inst_vld) begin
        if (fdp_swc) begin
          ns[run] = thr_done[run] ? 1 : 3;
          dep = 1;
        end else if (m_cnt == QUANTUM - 1 && other > 0) begin
          ns[run] = 1;
          dep = 1;
        end
      end
    end
    if (!stall && (run < 0 || dep)) begin
      for (int k = 1; k <= NT; k++) begin
        j = (m_ptr + k) % NT;
        if (win < 0 && m_st[j] == 1 && thr_en[j]) win = j;
      end
    end
    if (win >= 0) begin
      ns[win] = 2; m_ptr = win; m_cnt = 0; sw = 1;
    end else if (run >= 0 && !stall && fdp_inst_vld && m_cnt < QUANTUM - 1) begin
      m_cnt++;
    end
    s = '0; w = '0;
    for (int i = 0; i < NT; i++) begin
      s[i] = (ns[i] == 2);
      w[i] = (ns[i] == 3);
      m_st[i] = ns[i];
    end
    exp_q.push_back({s, |s, w, sw});
  endtask

  // driver: one clock, then scoreboard compare of all registered outputs
  task automatic tick();
    logic [9:0] e;
    model_step();
    @(posedge rclk);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({sel_thr, sel_vld, thr_wait, switch_out} !== e) begin
      bad++;
      $display("FAIL scoreboard t=%0t got sel=%b vld=%b wait=%b sw=%b exp sel=%b vld=%b wait=%b sw=%b",
               $time, sel_thr, sel_vld, thr_wait, switch_out, e[9:6], e[5], e[4:1], e[0]);
    end
  endtask

  task automatic idle_inputs();
    fdp_inst_vld = 0; fdp_swc = 0; thr_done = '0; stall = 0;
  endtask

  task automatic test_reset();
    reset = 1; thr_en = '0; idle_inputs();
    repeat (2) @(posedge rclk);
    #1;
    total++;
    if ({sel_thr, sel_vld, thr_wait, switch_out} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got %b exp 0", {sel_thr, sel_vld, thr_wait, switch_out});
    end
    reset = 0;
    model_reset();
  endtask

  task automatic test_first_grant();
    thr_en = 4'b0001;
    tick();
    total++;
    if (sel_vld !== 1'b0) begin bad++; $display("FAIL first_grant_early got vld=%b exp 0", sel_vld); end
    tick();
    total++;
    if (sel_thr !== 4'b0001 || sel_vld !== 1'b1 || switch_out !== 1'b1) begin
      bad++;
      $display("FAIL first_grant got sel=%b vld=%b sw=%b exp 0001 1 1", sel_thr, sel_vld, switch_out);
    end
    tick();
    total++;
    if (switch_out !== 1'b0) begin bad++; $display("FAIL switch_pulse got %b exp 0", switch_out); end
  endtask

  task automatic test_rotate();
    logic [NT-1:0] order[4];
    order[0] = 4'b0100; order[1] = 4'b1000; order[2] = 4'b0001; order[3] = 4'b0000;
    thr_en = 4'b1111;
    tick();
    fdp_inst_vld = 1; fdp_swc = 1;
    tick();
    total++;
    if (sel_thr !== 4'b0010 || thr_wait !== 4'b0001) begin
      bad++;
      $display("FAIL swc_switch got sel=%b wait=%b exp 0010 0001", sel_thr, thr_wait);
    end
    fdp_inst_vld = 0; fdp_swc = 0; thr_done = 4'b0001;
    tick();
    total++;
    if (thr_wait !== 4'b0000) begin bad++; $display("FAIL done_release got wait=%b exp 0000", thr_wait); end
    thr_done = '0;
    for (int k = 0; k < 3; k++) begin
      fdp_inst_vld = 1; fdp_swc = 1;
      tick();
      total++;
      if (sel_thr !== order[k]) begin
        bad++;
        $display("FAIL rotate_%0d got sel=%b exp %b", k, sel_thr, order[k]);
      end
    end
    idle_inputs();
    thr_done = 4'b1110;
    tick();
    thr_done = '0;
  endtask

  task automatic test_quantum();
    fdp_inst_vld = 1; fdp_swc = 1;
    tick();
    fdp_swc = 0;
    total++;
    if (sel_thr !== 4'b0010) begin bad++; $display("FAIL quantum_setup got sel=%b exp 0010", sel_thr); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        total++;
        if (sel_thr !== 4'b0010) begin bad++; $display("FAIL quantum_early got sel=%b exp 0010", sel_thr); end
      end
    end
    total++;
    if (sel_thr !== 4'b0100 || switch_out !== 1'b1 || thr_wait[1] !== 1'b0) begin
      bad++;
      $display("FAIL quantum_force got sel=%b sw=%b wait=%b exp 0100 1 x0xx", sel_thr, switch_out, thr_wait);
    end
    thr_en = 4'b0100;
    for (int k = 0; k < 24; k++) tick();
    total++;
    if (sel_thr !== 4'b0100 || switch_out !== 1'b0) begin
      bad++;
      $display("FAIL quantum_sat got sel=%b sw=%b exp 0100 0", sel_thr, switch_out);
    end
    thr_en = 4'b1111; fdp_inst_vld = 0;
    tick();
    fdp_inst_vld = 1;
    tick();
    total++;
    if (sel_thr !== 4'b1000 || switch_out !== 1'b1) begin
      bad++;
      $display("FAIL quantum_resume got sel=%b sw=%b exp 1000 1", sel_thr, switch_out);
    end
    idle_inputs();
  endtask

  task automatic test_swc_done();
    int r;
    r = m_run();
    fdp_inst_vld = 1; fdp_swc = 1;
    thr_done = '0;
    if (r >= 0) thr_done[r] = 1'b1;
    tick();
    total++;
    if (r < 0 || thr_wait[r] !== 1'b0 || switch_out !== 1'b1 || sel_thr[r] !== 1'b0) begin
      bad++;
      $display("FAIL swc_done thr=%0d got wait=%b sw=%b sel=%b exp wait bit 0, sw 1", r, thr_wait, switch_out, sel_thr);
    end
    idle_inputs();
    thr_done = 4'b1111;
    tick();
    idle_inputs();
  endtask

  task automatic test_stall();
    int r;
    logic [NT-1:0] oh;
    r = m_run();
    oh = '0;
    if (r >= 0) oh[r] = 1'b1;
    stall = 1; fdp_inst_vld = 1; fdp_swc = 1;
    tick();
    total++;
    if (r < 0 || sel_thr !== oh || switch_out !== 1'b0 || thr_wait !== 4'b0000) begin
      bad++;
      $display("FAIL stall_hold got sel=%b sw=%b wait=%b exp %b 0 0000", sel_thr, switch_out, thr_wait, oh);
    end
    fdp_inst_vld = 0; fdp_swc = 0;
    thr_en = 4'b1111 & ~oh;
    tick();
    total++;
    if (sel_vld !== 1'b0 || sel_thr !== 4'b0000) begin
      bad++;
      $display("FAIL stall_disable got vld=%b sel=%b exp 0 0000", sel_vld, sel_thr);
    end
    tick();
    total++;
    if (sel_vld !== 1'b0 || switch_out !== 1'b0) begin
      bad++;
      $display("FAIL stall_nogrant got vld=%b sw=%b exp 0 0", sel_vld, switch_out);
    end
    stall = 0;
    tick();
    total++;
    if (switch_out !== 1'b1 || sel_vld !== 1'b1 || (sel_thr & oh) !== 4'b0000) begin
      bad++;
      $display("FAIL stall_release got sel=%b vld=%b sw=%b exp other thread granted", sel_thr, sel_vld, switch_out);
    end
    thr_en = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      if (m_run() != 2) begin
        fdp_inst_vld = 1; fdp_swc = 1; thr_done = '0;
        if (m_run() >= 0) thr_done[m_run()] = 1'b1;
        tick();
      end
    end
    thr_done = '0; fdp_inst_vld = 1; fdp_swc = 1;
    tick();
    idle_inputs();
    total++;
    if (thr_wait[2] !== 1'b1) begin bad++; $display("FAIL mid_wait got wait=%b exp bit2 set", thr_wait); end
    #2 reset = 1;
    #1;
    total++;
    if ({sel_thr, sel_vld, thr_wait, switch_out} !== 10'b0) begin
      bad++;
      $display("FAIL async_reset got %b exp 0", {sel_thr, sel_vld, thr_wait, switch_out});
    end
    @(posedge rclk);
    #1;
    reset = 0;
    model_reset();
    thr_en = 4'b1110;
    tick();
    tick();
    total++;
    if (sel_thr !== 4'b0010 || switch_out !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_grant got sel=%b sw=%b exp 0010 1", sel_thr, switch_out);
    end
    thr_en = 4'b1111;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NT; i++) thr_en[i] = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NT; i++) thr_done[i] = ($urandom_range(0, 3) == 0);
      fdp_inst_vld = ($urandom_range(0, 3) != 0);
      fdp_swc = ($urandom_range(0, 4) == 0);
      stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotate();
    test_quantum();
    test_swc_done();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
